sram_sprite_arbiter: RTL

SRAM_SPRITE_ARBITER -- requirements
Module: sram_sprite_arbiter

---
 rtl/sram_arb_pkg.sv | 19 +
 rtl/sram_arb_sprite_arbiter_top.sv | 19 +
 rtl/sram_arb_starve_cnt.sv | 40 ++++
 rtl/sram_sprite_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared owner tag type and default widths for the sprite SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_LOAD = 2'd2
  } owner_e;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_STARVE_LIMIT = 8;

  // Counter width able to hold the value 'limit' itself.
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/sram_arb_sprite_arbiter_top.sv
// Owner tag pipeline stage used by the arbiter top in sram_sprite_arbiter.sv.
module sram_arb_tag_stage
  import sram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  owner_e own_d,
  output owner_e own_q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_q <= OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

endmodule

// File: rtl/sram_arb_starve_cnt.sv
// Loader starvation counter: counts ungranted loader request cycles,
// saturating at STARVE_LIMIT; 'starved' forces the next contended grant.
module sram_arb_starve_cnt
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic l_req,
  input  logic l_gnt,
  output logic starved
);

  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (l_gnt) begin
      cnt_d = '0;
    end else if (l_req && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved = (cnt_q == LIMIT);

endmodule

// File: rtl/sram_sprite_arbiter.sv
// Display/loader arbiter for a single-port sprite SRAM with 2-cycle reads.
// Optional loader starvation guard: define SRAM_ARB_STARVE_GUARD_EN.
module sram_sprite_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_gnt,
  output logic                  d_valid,
  output logic [DATA_WIDTH-1:0] d_data,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_valid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_i,
  input  logic [DATA_WIDTH-1:0] sram_data_o
);

  logic starved;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  sram_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .l_req   (l_req),
    .l_gnt   (l_gnt),
    .starved (starved)
  );
`else
  assign starved = 1'b0;
`endif

  logic                  sram_en_q, sram_en_d;
  logic                  sram_we_q, sram_we_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] sram_data_i_q, sram_data_i_d;
  owner_e                own_p1_q, own_p1_d;
  owner_e                own_p2_q;
  logic [DATA_WIDTH-1:0] d_hold_q, d_hold_d;
  logic [DATA_WIDTH-1:0] l_hold_q, l_hold_d;

  // Grants are combinational; reset_n gating keeps them low while in reset.
  always_comb begin
    l_gnt = reset_n & l_req & (~d_req | starved);
    d_gnt = reset_n & d_req & ~l_gnt;
  end

  // Stage 1: capture the granted access onto the SRAM port and tag its owner.
  always_comb begin
    sram_en_d     = d_gnt | l_gnt;
    sram_we_d     = l_gnt & l_we;
    sram_addr_d   = sram_addr_q;
    sram_data_i_d = sram_data_i_q;
    own_p1_d      = OWN_NONE;
    if (d_gnt) begin
      sram_addr_d = d_addr;
      own_p1_d    = OWN_DISP;
    end else if (l_gnt) begin
      sram_addr_d = l_addr;
      if (l_we) begin
        sram_data_i_d = l_wdata;
      end else begin
        own_p1_d = OWN_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_en_q     <= 1'b0;
      sram_we_q     <= 1'b0;
      sram_addr_q   <= '0;
      sram_data_i_q <= '0;
    end else begin
      sram_en_q     <= sram_en_d;
      sram_we_q     <= sram_we_d;
      sram_addr_q   <= sram_addr_d;
      sram_data_i_q <= sram_data_i_d;
    end
  end

  sram_arb_tag_stage u_tag_p1 (
    .clk     (clk),
    .reset_n (reset_n),
    .own_d   (own_p1_d),
    .own_q   (own_p1_q)
  );

  // Stage 2: the tag lines up with the SRAM's registered read data.
  sram_arb_tag_stage u_tag_p2 (
    .clk     (clk),
    .reset_n (reset_n),
    .own_d   (own_p1_q),
    .own_q   (own_p2_q)
  );

  always_comb begin
    d_valid  = (own_p2_q == OWN_DISP);
    l_valid  = (own_p2_q == OWN_LOAD);
    d_data   = d_valid ? sram_data_o : d_hold_q;
    l_rdata  = l_valid ? sram_data_o : l_hold_q;
    d_hold_d = d_data;
    l_hold_d = l_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_hold_q <= '0;
      l_hold_q <= '0;
    end else begin
      d_hold_q <= d_hold_d;
      l_hold_q <= l_hold_d;
    end
  end

  assign sram_en     = sram_en_q;
  assign sram_we     = sram_we_q;
  assign sram_addr   = sram_addr_q;
  assign sram_data_i = sram_data_i_q;

endmodule
